// File: rtl/codificador_matriz.sv
// 4x2 key-matrix scanner: column drive, per-key debounce, priority encoding and press-event pulse.
// Optional macro LINHA_SYNC_EN adds a 2-flop synchronizer on the row inputs.
module codificador_matriz #(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_COUNT = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Linha,
  output logic [1:0] Coluna,
  output logic [7:0] CH,
  output logic [2:0] Codigo,
  output logic       Valido,
  output logic       Evento
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEB_COUNT > 0) ? $clog2(DEB_COUNT + 1) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_COUNT - 1);
  localparam logic [2:0] ORDER [8] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5, 3'd7};

  typedef enum logic {COL0 = 1'b0, COL1 = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   dwell;
  logic [3:0]      linha_s;
  logic            sample;
  logic            col_sel;
  logic [DW-1:0]   deb [8];
  logic [7:0]      ch_prev;

`ifdef LINHA_SYNC_EN
  logic [3:0] sync1;
  logic [3:0] sync2;

  // Two-stage synchronizer for the asynchronous row lines
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= Linha;
      sync2 <= sync1;
    end
  end

  assign linha_s = sync2;
`else
  assign linha_s = Linha;
`endif

  assign sample  = (dwell == DWELL_LAST);
  assign col_sel = (state == COL1);

  // Column scan FSM with dwell counter and registered one-hot column drive
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= COL0;
      dwell  <= '0;
      Coluna <= 2'b01;
    end else if (sample) begin
      dwell <= '0;
      case (state)
        COL0: begin
          state  <= COL1;
          Coluna <= 2'b10;
        end
        COL1: begin
          state  <= COL0;
          Coluna <= 2'b01;
        end
        default: begin
          state  <= COL0;
          Coluna <= 2'b01;
        end
      endcase
    end else begin
      dwell <= dwell + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Per-key debounce; only the four keys of the driven column see the sample
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      CH <= 8'h00;
      for (int k = 0; k < 8; k++) deb[k] <= '0;
    end else if (sample) begin
      for (int k = 0; k < 8; k++) begin
        if (k[0] == col_sel) begin
          if (linha_s[k/2] == CH[k]) begin
            deb[k] <= '0;
          end else if (deb[k] == DEB_LAST) begin
            CH[k]  <= ~CH[k];
            deb[k] <= '0;
          end else begin
            deb[k] <= deb[k] + {{(DW-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

  // Press event: one pulse per cycle in which any key went 0->1
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ch_prev <= 8'h00;
      Evento  <= 1'b0;
    end else begin
      ch_prev <= CH;
      Evento  <= |(CH & ~ch_prev);
    end
  end

  // Priority encoder: walk from lowest to highest priority so the last hit wins
  always_comb begin
    Codigo = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      Codigo = CH[ORDER[i]] ? ORDER[i] : Codigo;
    end
    Valido = |CH;
  end

endmodule

// File: tb/tb_codificador_matriz.sv
// Scoreboard bench for codificador_matriz with SCAN_DIV=8, DEB_COUNT=3 (16-cycle scan period).
module tb_codificador_matriz;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] Linha;
  logic [1:0] Coluna;
  logic [7:0] CH;
  logic [2:0] Codigo;
  logic       Valido;
  logic       Evento;

  always #5 Clock = ~Clock;

  codificador_matriz #(.SCAN_DIV(8), .DEB_COUNT(3)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Linha (Linha),
    .Coluna(Coluna),
    .CH    (CH),
    .Codigo(Codigo),
    .Valido(Valido),
    .Evento(Evento)
  );

  typedef struct packed {
    logic [1:0] col;
    logic [7:0] ch;
    logic [2:0] cod;
    logic       val;
    logic       ev;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         evt_cnt = 0;
  int         m_cyc;
  int         m_deb [8];
  logic [7:0] m_ch;
  logic [7:0] m_chp;
  logic       m_ev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] prio(input logic [7:0] c);
    if (c[0]) return 3'd0;
    else if (c[2]) return 3'd2;
    else if (c[4]) return 3'd4;
    else if (c[6]) return 3'd6;
    else if (c[1]) return 3'd1;
    else if (c[3]) return 3'd3;
    else if (c[5]) return 3'd5;
    else if (c[7]) return 3'd7;
    else return 3'd0;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.col = (((m_cyc / 8) % 2) == 1) ? 2'b10 : 2'b01;
    e.ch  = m_ch;
    e.cod = prio(m_ch);
    e.val = (m_ch != 8'h00);
    e.ev  = m_ev;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_cyc = 0;
    m_ch  = 8'h00;
    m_chp = 8'h00;
    m_ev  = 1'b0;
    for (int k = 0; k < 8; k++) m_deb[k] = 0;
    q.delete();
    push_exp();
  endtask

  // Reference behaviour of one rising edge, then queue what the next cycle must show
  task automatic model_edge(input logic [3:0] lin);
    int col;
    int k;
    logic rose;
    rose  = |(m_ch & ~m_chp);
    m_chp = m_ch;
    if ((m_cyc % 8) == 7) begin
      col = (m_cyc / 8) % 2;
      for (int r = 0; r < 4; r++) begin
        k = 2 * r + col;
        if (lin[r] == m_ch[k]) m_deb[k] = 0;
        else if (m_deb[k] + 1 == 3) begin
          m_ch[k]  = ~m_ch[k];
          m_deb[k] = 0;
        end else m_deb[k] = m_deb[k] + 1;
      end
    end
    m_ev  = rose;
    m_cyc = m_cyc + 1;
    push_exp();
  endtask

  // One cycle: compare the queued expectation, drive rows, advance to next falling edge
  task automatic cyc(input logic [3:0] lin);
    exp_t e;
    if (q.size() == 0) begin
      check("queue_depth", 32'(q.size()), 32'd1);
    end else begin
      e = q.pop_front();
      check("coluna", 32'(Coluna), 32'(e.col));
      check("ch",     32'(CH),     32'(e.ch));
      check("codigo", 32'(Codigo), 32'(e.cod));
      check("valido", 32'(Valido), 32'(e.val));
      check("evento", 32'(Evento), 32'(e.ev));
    end
    if (Evento) evt_cnt++;
    Linha = lin;
    model_edge(lin);
    @(negedge Clock);
  endtask

  task automatic run_periods(input int p, input logic [3:0] l0, input logic [3:0] l1);
    for (int i = 0; i < p * 16; i++) begin
      cyc(((m_cyc % 16) < 8) ? l0 : l1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    Linha = 4'b0000;
    repeat (2) @(negedge Clock);
    check("rst_coluna", 32'(Coluna), 32'h1);
    check("rst_ch",     32'(CH),     32'h0);
    check("rst_codigo", 32'(Codigo), 32'h0);
    check("rst_valido", 32'(Valido), 32'h0);
    check("rst_evento", 32'(Evento), 32'h0);
    Reset = 1'b0;
    model_reset();

    // Idle scan
    evt_cnt = 0;
    run_periods(2, 4'b0000, 4'b0000);
    check("idle_evt", 32'(evt_cnt), 32'd0);

    // Single press on column 1, row 2 -> CH[5]
    evt_cnt = 0;
    run_periods(4, 4'b0000, 4'b0100);
    check("single_ch",  32'(CH),     32'h20);
    check("single_cod", 32'(Codigo), 32'd5);
    check("single_val", 32'(Valido), 32'd1);
    run_periods(3, 4'b0000, 4'b0000);
    check("single_rel", 32'(CH),      32'h00);
    check("single_evt", 32'(evt_cnt), 32'd1);

    // Bounce on key 0: high, low, then steady high
    evt_cnt = 0;
    run_periods(1, 4'b0001, 4'b0000);
    run_periods(1, 4'b0000, 4'b0000);
    run_periods(2, 4'b0001, 4'b0000);
    check("bounce_hold", 32'(CH), 32'h00);
    run_periods(1, 4'b0001, 4'b0000);
    check("bounce_set", 32'(CH), 32'h01);
    run_periods(3, 4'b0000, 4'b0000);
    check("bounce_rel", 32'(CH),      32'h00);
    check("bounce_evt", 32'(evt_cnt), 32'd1);

    // Priority: CH[7] then CH[4]
    evt_cnt = 0;
    run_periods(4, 4'b0000, 4'b1000);
    check("prio_cod7", 32'(Codigo), 32'd7);
    run_periods(3, 4'b0100, 4'b1000);
    check("prio_ch",   32'(CH),     32'h90);
    check("prio_cod4", 32'(Codigo), 32'd4);
    run_periods(3, 4'b0000, 4'b1000);
    check("prio_back7", 32'(Codigo), 32'd7);
    run_periods(3, 4'b0000, 4'b0000);
    check("prio_rel", 32'(CH),      32'h00);
    check("prio_evt", 32'(evt_cnt), 32'd2);

    // Simultaneous press of column 0 rows 0 and 3
    evt_cnt = 0;
    run_periods(3, 4'b1001, 4'b0000);
    check("simul_ch",  32'(CH),     32'h41);
    check("simul_cod", 32'(Codigo), 32'd0);
    check("simul_evt", 32'(evt_cnt), 32'd1);
    run_periods(3, 4'b0000, 4'b0000);
    check("simul_rel", 32'(CH), 32'h00);

    // Reset after two of three press samples
    run_periods(2, 4'b0001, 4'b0000);
    check("mid_pre", 32'(CH), 32'h00);
    Reset = 1'b1;
    #1;
    check("mid_rst_col", 32'(Coluna), 32'h1);
    check("mid_rst_ch",  32'(CH),     32'h00);
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
    run_periods(2, 4'b0001, 4'b0000);
    check("mid_two", 32'(CH), 32'h00);
    run_periods(1, 4'b0001, 4'b0000);
    check("mid_three", 32'(CH), 32'h01);
    run_periods(3, 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
